// File: rtl/dfe_round_satu.sv
// Multi-channel round-half-up/truncate then clip stage with clip flags, sticky flags and windowed clip counts.
// Latency 2 cycles in to out (flags/counts at +3); full rate, no backpressure.
module dfe_round_satu #(
  parameter int DIN_WIDTH  = 39,
  parameter int DOUT_WIDTH = 17,
  parameter int FRAC_DROP  = 0,
  parameter int NCH        = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic [NCH*DIN_WIDTH-1:0]  i_data,
  input  logic                      i_rnd_en,
  input  logic                      i_sym_en,
  input  logic [CNT_WIDTH-1:0]      i_win_len,
  input  logic                      i_clr,
  output logic                      o_valid,
  output logic [NCH*DOUT_WIDTH-1:0] o_data,
  output logic [NCH-1:0]            o_satu,
  output logic [NCH-1:0]            o_satu_sticky,
  output logic [NCH*CNT_WIDTH-1:0]  o_satu_cnt,
  output logic                      o_cnt_upd
);

  localparam int SW = DIN_WIDTH + 1;
  localparam int RW = SW - FRAC_DROP;
  localparam logic signed [RW-1:0] HI = {{(RW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};

  logic [SW-1:0]          rnd_add;
  logic signed [RW-1:0]   s1_next [NCH];
  logic signed [RW-1:0]   s1_r    [NCH];
  logic                   s1_vld;
  logic signed [RW-1:0]   lo_lim;
  logic [NCH*DOUT_WIDTH-1:0] dat_next;
  logic [NCH-1:0]         sat_next;
  logic [CNT_WIDTH-1:0]   win_cnt;
  logic [CNT_WIDTH-1:0]   acc     [NCH];
  logic [CNT_WIDTH-1:0]   acc_nxt [NCH];

  generate
    if (FRAC_DROP > 0) begin : g_rnd
      always_comb begin
        rnd_add = '0;
        rnd_add[FRAC_DROP-1] = i_rnd_en;
      end
    end else begin : g_no_rnd
      logic unused_rnd_en;
      assign unused_rnd_en = i_rnd_en;
      assign rnd_add = '0;
    end
  endgenerate

  // One guard bit above the input keeps the rounding add from wrapping at max positive.
  for (genvar k = 0; k < NCH; k++) begin : g_s1
    logic signed [SW-1:0] sum;
    assign sum = $signed({i_data[k*DIN_WIDTH+DIN_WIDTH-1], i_data[k*DIN_WIDTH +: DIN_WIDTH]})
               + $signed(rnd_add);
    assign s1_next[k] = RW'(sum >>> FRAC_DROP);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld <= 1'b0;
      for (int k = 0; k < NCH; k++) s1_r[k] <= '0;
    end else begin
      s1_vld <= i_valid;
      if (i_valid) begin
        for (int k = 0; k < NCH; k++) s1_r[k] <= s1_next[k];
      end
    end
  end

  assign lo_lim = i_sym_en ? -HI : ~HI;

  always_comb begin
    dat_next = '0;
    sat_next = '0;
    for (int k = 0; k < NCH; k++) begin
      if (s1_r[k] > HI) begin
        dat_next[k*DOUT_WIDTH +: DOUT_WIDTH] = HI[DOUT_WIDTH-1:0];
        sat_next[k] = 1'b1;
      end else if (s1_r[k] < lo_lim) begin
        dat_next[k*DOUT_WIDTH +: DOUT_WIDTH] = lo_lim[DOUT_WIDTH-1:0];
        sat_next[k] = 1'b1;
      end else begin
        dat_next[k*DOUT_WIDTH +: DOUT_WIDTH] = s1_r[k][DOUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_satu  <= '0;
    end else begin
      o_valid <= s1_vld;
      o_satu  <= s1_vld ? sat_next : '0;
      if (s1_vld) o_data <= dat_next;
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      acc_nxt[k] = (o_satu[k] && (acc[k] != '1)) ? acc[k] + 1'b1 : acc[k];
    end
  end

  // Clear wins over everything: the colliding sample is neither counted nor flagged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_cnt       <= '0;
      o_satu_sticky <= '0;
      o_satu_cnt    <= '0;
      o_cnt_upd     <= 1'b0;
      for (int k = 0; k < NCH; k++) acc[k] <= '0;
    end else begin
      o_cnt_upd <= 1'b0;
      if (i_clr) begin
        win_cnt       <= '0;
        o_satu_sticky <= '0;
        o_satu_cnt    <= '0;
        for (int k = 0; k < NCH; k++) acc[k] <= '0;
      end else begin
        if (o_valid) o_satu_sticky <= o_satu_sticky | o_satu;
        if (i_win_len == '0) begin
          win_cnt <= '0;
          for (int k = 0; k < NCH; k++) acc[k] <= '0;
        end else if (o_valid) begin
          if (win_cnt >= i_win_len - 1'b1) begin
            win_cnt   <= '0;
            o_cnt_upd <= 1'b1;
            for (int k = 0; k < NCH; k++) begin
              o_satu_cnt[k*CNT_WIDTH +: CNT_WIDTH] <= acc_nxt[k];
              acc[k] <= '0;
            end
          end else begin
            win_cnt <= win_cnt + 1'b1;
            for (int k = 0; k < NCH; k++) acc[k] <= acc_nxt[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dfe_round_satu.sv
// Directed bench for dfe_round_satu at DIN=16, DOUT=8, FRAC_DROP=4, NCH=2.
module tb_dfe_round_satu;
  localparam int DW = 16, OW = 8, FD = 4, NC = 2, CW = 16;

  logic               i_clk = 1'b0;
  logic               i_rst, i_valid, i_rnd_en, i_sym_en, i_clr;
  logic [NC*DW-1:0]   i_data;
  logic [CW-1:0]      i_win_len;
  logic               o_valid, o_cnt_upd;
  logic [NC*OW-1:0]   o_data;
  logic [NC-1:0]      o_satu, o_satu_sticky;
  logic [NC*CW-1:0]   o_satu_cnt;

  int n_checks = 0;
  int n_errors = 0;

  dfe_round_satu #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .FRAC_DROP(FD), .NCH(NC), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_rnd_en(i_rnd_en), .i_sym_en(i_sym_en), .i_win_len(i_win_len), .i_clr(i_clr),
    .o_valid(o_valid), .o_data(o_data), .o_satu(o_satu), .o_satu_sticky(o_satu_sticky),
    .o_satu_cnt(o_satu_cnt), .o_cnt_upd(o_cnt_upd)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d0, input logic [15:0] d1);
    i_valid = v;
    i_data  = {d1, d0};
  endtask

  // One isolated sample: outputs checked at n+2, sticky at n+3.
  task automatic send_chk(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                          input logic [7:0] e0, input logic [7:0] e1,
                          input logic [1:0] esat, input logic [1:0] estk);
    drive(1'b1, d0, d1);
    cyc;
    drive(1'b0, 16'h0, 16'h0);
    cyc;
    chk({tag, "_vld"}, 32'(o_valid), 32'd1);
    chk({tag, "_d0"}, 32'(o_data[7:0]), 32'(e0));
    chk({tag, "_d1"}, 32'(o_data[15:8]), 32'(e1));
    chk({tag, "_sat"}, 32'(o_satu), 32'(esat));
    cyc;
    chk({tag, "_stk"}, 32'(o_satu_sticky), 32'(estk));
  endtask

  initial begin
    int c;
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_rnd_en = 1'b0; i_sym_en = 1'b0;
    i_clr = 1'b0; i_win_len = '0;
    cyc; cyc;
    chk("rst_vld", 32'(o_valid), 32'd0);
    chk("rst_dat", 32'(o_data), 32'd0);
    chk("rst_sat", 32'(o_satu), 32'd0);
    chk("rst_stk", 32'(o_satu_sticky), 32'd0);
    chk("rst_cnt", o_satu_cnt, 32'd0);
    chk("rst_upd", 32'(o_cnt_upd), 32'd0);
    i_rst = 1'b0;
    cyc;

    i_rnd_en = 1'b1; cyc; cyc;
    send_chk("rnd_up", 16'h0128, 16'h0000, 8'h13, 8'h00, 2'b00, 2'b00);
    i_rnd_en = 1'b0; cyc; cyc;
    send_chk("trunc", 16'h0128, 16'h0000, 8'h12, 8'h00, 2'b00, 2'b00);
    i_rnd_en = 1'b1; cyc; cyc;
    send_chk("rnd_neg", 16'hFFE8, 16'h0000, 8'hFF, 8'h00, 2'b00, 2'b00);
    send_chk("pos_clip", 16'h7FFF, 16'h0000, 8'h7F, 8'h00, 2'b01, 2'b01);
    send_chk("asym_f800", 16'hF800, 16'h0000, 8'h80, 8'h00, 2'b00, 2'b01);
    send_chk("asym_8000", 16'h8000, 16'h0128, 8'h80, 8'h13, 2'b01, 2'b01);
    i_sym_en = 1'b1; cyc; cyc;
    send_chk("sym_f800", 16'hF800, 16'h0000, 8'h81, 8'h00, 2'b01, 2'b01);
    send_chk("sym_8000", 16'h0000, 16'h8000, 8'h00, 8'h81, 2'b10, 2'b11);

    i_clr = 1'b1; cyc; i_clr = 1'b0;
    chk("clr_stk", 32'(o_satu_sticky), 32'd0);

    // Window of 4, ch0 clips on samples 1, 2 and 6.
    i_sym_en = 1'b0; i_win_len = 16'd4; cyc; cyc;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(1'b1, (i == 1 || i == 2 || i == 6) ? 16'h7FFF : 16'h0010, 16'h0000);
      else       drive(1'b0, 16'h0, 16'h0);
      cyc;
      c = i + 1;
      chk("win_upd", 32'(o_cnt_upd), 32'(c == 6 || c == 10));
      if (c == 6) begin
        chk("win1_c0", 32'(o_satu_cnt[15:0]), 32'd2);
        chk("win1_c1", 32'(o_satu_cnt[31:16]), 32'd0);
      end
      if (c == 10) begin
        chk("win2_c0", 32'(o_satu_cnt[15:0]), 32'd1);
        chk("win2_c1", 32'(o_satu_cnt[31:16]), 32'd0);
      end
    end

    // Clear lands on the clipping sample that would complete the window.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h7FFF, 16'h0000);
      cyc;
    end
    drive(1'b0, 16'h0, 16'h0);
    cyc;
    chk("col_vld", 32'(o_valid), 32'd1);
    chk("col_sat", 32'(o_satu), 32'd1);
    chk("col_stk_pre", 32'(o_satu_sticky), 32'd1);
    i_clr = 1'b1; cyc; i_clr = 1'b0;
    chk("col_upd", 32'(o_cnt_upd), 32'd0);
    chk("col_stk", 32'(o_satu_sticky), 32'd0);
    chk("col_cnt", o_satu_cnt, 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, (i == 0) ? 16'h7FFF : 16'h0010, 16'h0000);
      cyc;
      c = i + 1;
      chk("post_upd", 32'(o_cnt_upd), 32'(c == 6));
      if (c == 6) chk("post_cnt", o_satu_cnt, 32'd1);
    end

    // Valid 1-0-1: data holds through the gap.
    drive(1'b1, 16'h0128, 16'h0010); cyc;
    drive(1'b0, 16'h0, 16'h0);       cyc;
    drive(1'b1, 16'hFFE8, 16'h0000);
    chk("gap_vld0", 32'(o_valid), 32'd1);
    chk("gap_dat0", 32'(o_data), 32'h0113);
    cyc;
    drive(1'b0, 16'h0, 16'h0);
    chk("gap_vld1", 32'(o_valid), 32'd0);
    chk("gap_hold", 32'(o_data), 32'h0113);
    chk("gap_sat1", 32'(o_satu), 32'd0);
    cyc;
    chk("gap_vld2", 32'(o_valid), 32'd1);
    chk("gap_dat2", 32'(o_data), 32'h00FF);
    cyc; cyc;

    // Reset with two clipping samples in flight.
    drive(1'b1, 16'h7FFF, 16'h7FFF); cyc;
    drive(1'b1, 16'h7FFF, 16'h0000); cyc;
    drive(1'b0, 16'h0, 16'h0);
    chk("rst2_pre", 32'(o_valid), 32'd1);
    i_rst = 1'b1; cyc; i_rst = 1'b0;
    chk("rst2_vld", 32'(o_valid), 32'd0);
    chk("rst2_dat", 32'(o_data), 32'd0);
    chk("rst2_sat", 32'(o_satu), 32'd0);
    chk("rst2_stk", 32'(o_satu_sticky), 32'd0);
    chk("rst2_cnt", o_satu_cnt, 32'd0);
    chk("rst2_upd", 32'(o_cnt_upd), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("rst2_stale", 32'(o_valid), 32'd0);
    end
    drive(1'b1, 16'h0128, 16'h0000); cyc;
    drive(1'b0, 16'h0, 16'h0);
    chk("lat_n1", 32'(o_valid), 32'd0);
    cyc;
    chk("lat_n2", 32'(o_valid), 32'd1);
    chk("lat_dat", 32'(o_data[7:0]), 32'h13);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dfe_round_satu.md
# dfe_round_satu

Multi-channel round-and-saturate stage for the DFE datapath, the parametrised successor of the single-channel saturator. It drops `FRAC_DROP` LSBs with optional round-half-up, then clips to `DOUT_WIDTH` with optional symmetric range. It carries a valid qualifier and reports per-sample clip flags, sticky flags and windowed clip counts for gain-control firmware. It sits between filter/NCO accumulators and the next DFE stage.

## Interface
- `DIN_WIDTH`, 39, input sample width per channel, two's complement
- `DOUT_WIDTH`, 17, output sample width per channel; requires `DIN_WIDTH - FRAC_DROP >= DOUT_WIDTH`
- `FRAC_DROP`, 0, LSBs removed before saturation; 0 disables rounding entirely
- `NCH`, 2, channel count; channel k occupies bits `[k*W +: W]` of packed buses
- `CNT_WIDTH`, 16, width of window length and clip counters
- `i_clk`  in  1  single clock; all logic on rising edge
- `i_rst`  in  1  reset, synchronous and active-high
- `i_valid`  in  1  input sample qualifier, common to all channels
- `i_data`  in  NCH*DIN_WIDTH  packed input samples
- `i_rnd_en`  in  1  1: round-half-up (add 2^(FRAC_DROP-1) before shift); 0: truncate (floor)
- `i_sym_en`  in  1  1: negative limit is -(2^(DOUT_WIDTH-1)-1); 0: it is -2^(DOUT_WIDTH-1)
- `i_win_len`  in  CNT_WIDTH  measurement window length in output samples; 0 disables windowing
- `i_clr`  in  1  single-cycle clear of sticky flags, accumulators, window counter and `o_satu_cnt`
- `o_valid`  out  1  output qualifier
- `o_data`  out  NCH*DOUT_WIDTH  packed saturated samples
- `o_satu`  out  NCH  per-channel clip flag, aligned with `o_data`, valid only while `o_valid`
- `o_satu_sticky`  out  NCH  set on any clip, held until `i_clr` or reset
- `o_satu_cnt`  out  NCH*CNT_WIDTH  clip count of the last completed window
- `o_cnt_upd`  out  1  one-cycle pulse when `o_satu_cnt` takes a new value

## Operation
- Stage 1, per channel: `r = sext(x, DIN_WIDTH+1) + (i_rnd_en && FRAC_DROP>0 ? 2^(FRAC_DROP-1) : 0)`, then arithmetic shift right by `FRAC_DROP`. The extra bit prevents wrap at the maximum positive input. Register the result with the valid bit.
- Stage 2, per channel: `hi = 2^(DOUT_WIDTH-1)-1`; `lo = i_sym_en ? -hi : -hi-1`.
  - r > hi: output hi, `o_satu` = 1.
  - r < lo: output lo, `o_satu` = 1.
  - Otherwise output the low `DOUT_WIDTH` bits of r, `o_satu` = 0.
- When `i_valid` = 0, no sample enters the pipeline. `o_data` holds its last value; `o_valid` = 0 and `o_satu` = 0 in that cycle.
- `i_rnd_en`, `i_sym_en` and `i_win_len` are quasi-static. They are changed only after `i_valid` has been low for 2 cycles; otherwise the result is undefined for in-flight samples.
- Window logic runs on registered `o_valid` / `o_satu`:
  - `win_cnt` increments per `o_valid`.
  - Each `acc[k]` increments per `o_valid & o_satu[k]`, saturating at all-ones.
  - On the `o_valid` where `win_cnt == i_win_len-1`, next cycle: `o_satu_cnt[k]` = final `acc[k]` including this sample; acc and `win_cnt` cleared; `o_cnt_upd` = 1.
- `i_win_len` = 0: `win_cnt` and acc held at 0, `o_cnt_upd` never pulses, and `o_satu_cnt` holds its value.
- `o_satu_sticky[k]` is set the cycle after `o_valid & o_satu[k]`.
- `i_clr` priority: it overrides any simultaneous increment, window completion or sticky set in the same cycle. That sample is not counted and no `o_cnt_upd` is issued.

## Timing
- Reset values: `o_valid`, `o_data`, `o_satu`, `o_satu_sticky`, `o_satu_cnt`, `o_cnt_upd` all 0. Pipeline valids, acc and `win_cnt` are also 0.
- Reset asserted mid-stream discards in-flight samples. The first `o_valid` after reset release comes 2 cycles after the first accepted `i_valid`.
- Latency: `i_valid` at cycle n gives `o_valid` / `o_data` / `o_satu` at n+2. The sticky update and any `o_cnt_upd` for that sample occur at n+3.
- Full throughput: one sample per channel per cycle; no backpressure.
- Counter saturation: acc stops at 2^CNT_WIDTH-1 and does not wrap.

## Test plan
Parameters: `DIN_WIDTH`=16, `DOUT_WIDTH`=8, `FRAC_DROP`=4, `NCH`=2.

- Rounding: ch0 = 0x0128 with `i_rnd_en`=1 gives 19 (0x13), `o_satu`=0; with `i_rnd_en`=0 gives 18. Input -24 with round gives -1 (0xFF).
- Positive clip: 0x7FFF with round gives 0x7F, `o_satu[0]`=1 at n+2 and sticky[0]=1 at n+3. Ch1 = 0x0000 in the same sample gives 0, `o_satu[1]`=0.
- Symmetric mode: 0xF800 with round gives 0x80 (no clip) when `i_sym_en`=0, and 0x81 with `o_satu`=1 when `i_sym_en`=1. 0x8000 gives 0x80 or 0x81 with clip.
- Window: `i_win_len`=4; stream 8 samples with ch0 clipping on samples 1, 2 and 6. `o_cnt_upd` pulses at cycles n+3+3 and n+3+7 with ch0 counts 2 then 1; ch1 count is 0.
- Clear collision: assert `i_clr` in the cycle a clip would increment acc and complete the window. Required: acc = 0, no `o_cnt_upd`, sticky = 0, `o_satu_cnt` = 0.
- Gapped valid plus reset: toggle `i_valid` 1-0-1. Check `o_data` holds during the gap and latency stays 2. Assert `i_rst` with 2 samples in flight: all outputs 0 next cycle, and no stale `o_valid` appears afterwards.
